// File: rtl/ethernet_pkt_buf.sv
// ethernet_pkt_buf
// Byte-wide circular packet buffer feeding the Ethernet transmitter.
// Capture-side bytes are stored as they arrive. Once PKT_LEN bytes are
// held, pkt_ready is raised. Exactly PKT_LEN bytes are then delivered on
// rd_en requests, and an inter-packet gap follows before the next packet
// can be announced.
//
// Ports:
//   clk        system clock (single domain)
//   rst        synchronous reset, active low
//   din        write byte from video capture
//   din_valid  write strobe, one byte per cycle
//   full       buffer holds 2^ADDR_W bytes
//   overflow   sticky, set when a write is dropped
//   level      number of bytes currently stored
//   pkt_ready  a full payload is stored and not yet started
//   rd_en      byte request from the transmitter
//   dout       read byte, registered one clock after the accepted rd_en
//   dout_valid dout carries a payload byte this cycle
//   pkt_last   marks the final payload byte, aligned with dout_valid
module ethernet_pkt_buf #(
    parameter int PKT_LEN    = 1360,
    parameter int ADDR_W     = 12,
    parameter int IFG_CYCLES = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        din,
    input  logic              din_valid,
    output logic              full,
    output logic              overflow,
    output logic [ADDR_W:0]   level,
    output logic              pkt_ready,
    input  logic              rd_en,
    output logic [7:0]        dout,
    output logic              dout_valid,
    output logic              pkt_last
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LVL_W = ADDR_W + 1;
    localparam int CNT_W = ($clog2(PKT_LEN + 1) > 11) ? $clog2(PKT_LEN + 1) : 11;
    localparam int GAP_W = ($clog2(IFG_CYCLES + 1) > 1) ? $clog2(IFG_CYCLES + 1) : 1;

    localparam logic [LVL_W-1:0] PKT_LVL = LVL_W'(PKT_LEN);
    localparam logic [CNT_W-1:0] PKT_CNT = CNT_W'(PKT_LEN);
    localparam logic [GAP_W-1:0] GAP_END = GAP_W'(IFG_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        STREAM,
        GAP
    } state_t;

    state_t              state;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]    byte_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic                wr_acc;
    logic                pop;

    // Level can only reach 2^ADDR_W when the top bit is set.
    assign full = level[ADDR_W];

    // full is the registered level, so a same-cycle pop never frees room
    // for the write arriving in that cycle.
    always_comb begin
        wr_acc = din_valid && !full;
        pop    = rd_en && ((state == ARMED) || (state == STREAM));
    end

    always_ff @(posedge clk) begin
        if (rst && wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            byte_cnt   <= '0;
            gap_cnt    <= '0;
            overflow   <= 1'b0;
            pkt_ready  <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            pkt_last   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (din_valid && full) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end

            case ({wr_acc, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            dout_valid <= pop;
            pkt_last   <= 1'b0;

            case (state)
                IDLE: begin
                    if (level >= PKT_LVL) begin
                        state     <= ARMED;
                        pkt_ready <= 1'b1;
                    end
                end
                ARMED: begin
                    if (pop) begin
                        pkt_ready <= 1'b0;
                        byte_cnt  <= CNT_W'(1);
                        if (PKT_LEN == 1) begin
                            state    <= GAP;
                            gap_cnt  <= '0;
                            pkt_last <= 1'b1;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (pop) begin
                        byte_cnt <= byte_cnt + CNT_W'(1);
                        if (byte_cnt + CNT_W'(1) == PKT_CNT) begin
                            state    <= GAP;
                            gap_cnt  <= '0;
                            pkt_last <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    // Gap occupies IFG_CYCLES+1 clocks so that the next
                    // pkt_ready lands IFG_CYCLES+2 clocks after the final pop.
                    if (gap_cnt == GAP_END) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ethernet_pkt_buf.sv
// Testbench for ethernet_pkt_buf: randomized and directed stimulus checked
// against a queue-based reference model of the packet buffer.
module tb_ethernet_pkt_buf;

    localparam int PKT_LEN = 1360;
    localparam int ADDR_W  = 12;
    localparam int IFG     = 24;
    localparam int DEPTH   = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        din = '0;
    logic              din_valid = 1'b0;
    logic              rd_en = 1'b0;
    logic              full;
    logic              overflow;
    logic [ADDR_W:0]   level;
    logic              pkt_ready;
    logic [7:0]        dout;
    logic              dout_valid;
    logic              pkt_last;

    always #20 clk = ~clk;

    ethernet_pkt_buf #(
        .PKT_LEN   (PKT_LEN),
        .ADDR_W    (ADDR_W),
        .IFG_CYCLES(IFG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .full      (full),
        .overflow  (overflow),
        .level     (level),
        .pkt_ready (pkt_ready),
        .rd_en     (rd_en),
        .dout      (dout),
        .dout_valid(dout_valid),
        .pkt_last  (pkt_last)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: stored bytes as a queue, packet progress as counters.
    logic [7:0] q[$];
    bit         m_ovf;
    bit         m_announced;
    int         m_sent;
    int         m_gap_left;
    bit         m_pop;
    bit         m_dv;
    bit         m_last;
    logic [7:0] m_dout;
    int         pkts_done;
    int         pops_total;
    int         last_pop_cyc;
    int         prev_size;

    // Per-test observations.
    int         n_valid;
    logic [7:0] last_byte;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf       = 1'b0;
        m_announced = 1'b0;
        m_sent      = 0;
        m_gap_left  = 0;
        m_pop       = 1'b0;
        m_dv        = 1'b0;
        m_last      = 1'b0;
        m_dout      = 8'h00;
        prev_size   = 0;
    endtask

    task automatic model_step(input logic dv, input logic [7:0] d, input logic re);
        int pre;
        pre       = q.size();
        prev_size = pre;
        m_pop     = re && m_announced;
        m_dv      = m_pop;
        m_last    = 1'b0;
        if (m_pop) m_dout = q.pop_front();
        if (dv) begin
            if (pre == DEPTH) m_ovf = 1'b1;
            else              q.push_back(d);
        end
        if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (!m_announced && pre >= PKT_LEN) begin
            m_announced = 1'b1;
            m_sent      = 0;
        end
        if (m_pop) begin
            pops_total++;
            m_sent++;
            if (m_sent == PKT_LEN) begin
                m_last       = 1'b1;
                m_announced  = 1'b0;
                m_gap_left   = IFG + 1;
                pkts_done++;
                last_pop_cyc = cyc;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("level", 32'(level), 32'(q.size()));
        check_eq("full", 32'(full), 32'(q.size() == DEPTH));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("pkt_ready", 32'(pkt_ready), 32'(m_announced && m_sent == 0));
        check_eq("dout_valid", 32'(dout_valid), 32'(m_dv));
        check_eq("dout", 32'(dout), 32'(m_dout));
        check_eq("pkt_last", 32'(pkt_last), 32'(m_last));
    endtask

    task automatic cycle(input logic dv, input logic [7:0] d, input logic re);
        din_valid = dv;
        din       = d;
        rd_en     = re;
        @(posedge clk);
        cyc++;
        model_step(dv, d, re);
        #1;
        compare_all();
        if (dout_valid) begin
            n_valid++;
            if (pkt_last) last_byte = dout;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        din_valid = 1'b0;
        rd_en     = 1'b0;
        @(posedge clk);
        cyc++;
        model_reset();
        #1;
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_pkt_ready", 32'(pkt_ready), 32'd0);
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_dout_valid", 32'(dout_valid), 32'd0);
        check_eq("rst_pkt_last", 32'(pkt_last), 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        int  base;
        int  budget;
        bit  measured;
        bit  prev_ready;

        pkts_done  = 0;
        pops_total = 0;
        model_reset();

        // Basic packet with incrementing data.
        do_reset();
        n_valid = 0;
        for (int i = 0; i < PKT_LEN; i++) cycle(1'b1, 8'(i), 1'b0);
        check_eq("ready_not_yet", 32'(pkt_ready), 32'd0);
        cycle(1'b0, 8'h00, 1'b0);
        check_eq("ready_2clk", 32'(pkt_ready), 32'd1);
        for (int i = 0; i < PKT_LEN + 40; i++) cycle(1'b0, 8'h00, 1'b1);
        check_eq("basic_count", 32'(n_valid), 32'(PKT_LEN));
        check_eq("basic_last_byte", 32'(last_byte), 32'h4F);

        // Back-to-back packets and gap timing, rd_en held high throughout.
        do_reset();
        base = pkts_done;
        measured = 1'b0;
        prev_ready = 1'b0;
        budget = 0;
        while (pkts_done < base + 2 && budget < 8000) begin
            cycle(budget < 2 * PKT_LEN, 8'($urandom), 1'b1);
            if (pkt_ready && !prev_ready && pkts_done == base + 1 && !measured) begin
                check_eq("gap_len", 32'(cyc - last_pop_cyc), 32'(IFG + 2));
                measured = 1'b1;
            end
            prev_ready = pkt_ready;
            budget++;
        end
        check_eq("gap_two_pkts", 32'(pkts_done - base), 32'd2);
        check_eq("gap_measured", 32'(measured), 32'd1);

        // Overflow then drain across the address wrap.
        do_reset();
        for (int i = 0; i < DEPTH + 4; i++) begin
            cycle(1'b1, 8'($urandom), 1'b0);
            if (i == DEPTH - 1) begin
                check_eq("ovf_full_at_depth", 32'(full), 32'd1);
                check_eq("ovf_not_yet", 32'(overflow), 32'd0);
            end
            if (i == DEPTH) check_eq("ovf_set", 32'(overflow), 32'd1);
        end
        check_eq("ovf_level_held", 32'(level), 32'(DEPTH));
        base = pkts_done;
        budget = 0;
        while (pkts_done < base + 4 && budget < 30000) begin
            cycle(1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
            budget++;
        end
        check_eq("wrap_four_pkts", 32'(pkts_done - base), 32'd4);

        // Concurrent writes every clock with alternating read requests.
        do_reset();
        base = pkts_done;
        budget = 0;
        while (pkts_done < base + 1 && budget < 6000) begin
            cycle(1'b1, 8'($urandom), 1'(budget));
            check_eq("lvl_step", 32'(level), 32'(prev_size + 1 - int'(m_pop)));
            budget++;
        end
        check_eq("conc_pkt", 32'(pkts_done - base), 32'd1);

        // Reset in the middle of a packet, then a fresh packet.
        do_reset();
        for (int i = 0; i < PKT_LEN; i++) cycle(1'b1, 8'($urandom), 1'b0);
        budget = 0;
        while (!pkt_ready && budget < 10) begin
            cycle(1'b0, 8'h00, 1'b0);
            budget++;
        end
        check_eq("mid_ready", 32'(pkt_ready), 32'd1);
        base = pops_total;
        for (int i = 0; i < 500; i++) cycle(1'b1, 8'($urandom), 1'b1);
        check_eq("mid_pops", 32'(pops_total - base), 32'd500);
        do_reset();
        base = pkts_done;
        n_valid = 0;
        for (int i = 0; i < PKT_LEN; i++) cycle(1'b1, 8'($urandom), 1'b0);
        budget = 0;
        while (pkts_done < base + 1 && budget < PKT_LEN + 20) begin
            cycle(1'b0, 8'h00, 1'b1);
            budget++;
        end
        cycle(1'b0, 8'h00, 1'b1);
        check_eq("post_rst_pkt", 32'(pkts_done - base), 32'd1);
        check_eq("post_rst_count", 32'(n_valid), 32'(PKT_LEN));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
